// File: rtl/myla_trig_capture.sv
// MyLA capture core: Wishbone slave sampling a probe bus into a pre-trigger ring,
// with mask/value trigger, post-trigger count, sample divider and done interrupt.
module myla_trig_capture #(
  parameter int DBITS   = 16,
  parameter int QBITS   = 4,
  parameter int DIVBITS = 16
) (
  input  logic             CLK_I,
  input  logic             RES_N_I,
  input  logic [2:0]       ADR_I,
  input  logic             WE_I,
  input  logic             CYC_I,
  input  logic             STB_I,
  input  logic [DBITS-1:0] DAT_I,
  output logic             ACK_O,
  output logic [DBITS-1:0] DAT_O,
  input  logic [DBITS-1:0] CHAN_I,
  input  logic             GATE_I,
  output logic             IRQ_O
);
  localparam int PBITS = QBITS + 1;

  typedef enum logic [1:0] {IDLE, ARMED, TRIG, DONE} state_t;

  state_t             state, state_nxt;
  logic [DBITS-1:0]   mem [2**QBITS];
  logic [QBITS-1:0]   rp, wp, rp_inc, wp_inc;
  logic               ovf;
  logic [DBITS-1:0]   mask, value;
  logic [DIVBITS-1:0] div, divcnt;
  logic [PBITS-1:0]   post, postcnt, postcnt_nxt, post_inc;
  logic               full, empty;
  logic               bus_wr, arm_wr, abort_wr, ovf_clr, pop;
  logic               sampling, tick, strobe, match;
  logic               capture, drop, ovf_set;
  logic [DBITS-1:0]   rdata;

  // Handshake: a request (CYC_I & STB_I) is answered by ACK_O one cycle later for exactly
  // one cycle; the master holds the request through the ACK_O cycle, where writes commit.
  assign bus_wr   = ACK_O & CYC_I & STB_I & WE_I;
  assign arm_wr   = bus_wr & (ADR_I == 3'd0) & DAT_I[0] & ~DAT_I[1];
  assign abort_wr = bus_wr & (ADR_I == 3'd0) & DAT_I[1];
  assign ovf_clr  = bus_wr & (ADR_I == 3'd0) & DAT_I[5];

  assign rp_inc = rp + QBITS'(1);
  assign wp_inc = wp + QBITS'(1);
  assign full   = (wp_inc == rp);
  assign empty  = (wp == rp);
  assign pop    = bus_wr & (ADR_I == 3'd1) & ~empty;

  // An ARM commit restarts everything, so no sample is taken in that cycle.
  assign sampling = ((state == ARMED) | (state == TRIG)) & ~arm_wr;
  assign tick     = (divcnt == '0);
  assign strobe   = sampling & tick & GATE_I;
  assign match    = ((CHAN_I ^ value) & mask) == '0;
  assign post_inc = postcnt + PBITS'(1);

  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    drop        = 1'b0;
    ovf_set     = 1'b0;
    postcnt_nxt = postcnt;
    case (state)
      ARMED: if (strobe) begin
        capture = 1'b1;
        drop    = full;
        if (match) begin
          postcnt_nxt = '0;
          state_nxt   = (post == '0) ? DONE : TRIG;
        end
      end
      TRIG: if (strobe) begin
        capture     = ~full;
        ovf_set     = full;
        postcnt_nxt = post_inc;
        if (post_inc == post) state_nxt = DONE;
      end
      default: ;
    endcase
    if (abort_wr)    state_nxt = IDLE;
    else if (arm_wr) state_nxt = ARMED;
  end

  always_ff @(posedge CLK_I or negedge RES_N_I) begin
    if (!RES_N_I) begin
      ACK_O   <= 1'b0;
      state   <= IDLE;
      rp      <= '0;
      wp      <= '0;
      ovf     <= 1'b0;
      mask    <= '0;
      value   <= '0;
      div     <= '0;
      post    <= '0;
      divcnt  <= '0;
      postcnt <= '0;
    end else begin
      ACK_O   <= CYC_I & STB_I & ~ACK_O;
      state   <= state_nxt;
      postcnt <= postcnt_nxt;
      if (arm_wr) begin
        rp     <= '0;
        wp     <= '0;
        divcnt <= '0;
      end else begin
        if (sampling) divcnt <= tick ? div : divcnt - DIVBITS'(1);
        if (capture)  wp <= wp_inc;
        // A ring drop and a host pop in the same cycle free a single slot.
        if (drop | pop) rp <= rp_inc;
      end
      if (arm_wr | ovf_clr) ovf <= 1'b0;
      else if (ovf_set)     ovf <= 1'b1;
      if (bus_wr && ADR_I == 3'd2) mask  <= DAT_I;
      if (bus_wr && ADR_I == 3'd3) value <= DAT_I;
      if (bus_wr && ADR_I == 3'd4) div   <= DAT_I[DIVBITS-1:0];
      if (bus_wr && ADR_I == 3'd5) post  <= DAT_I[PBITS-1:0];
    end
  end

  always_ff @(posedge CLK_I) begin
    if (capture) mem[wp] <= CHAN_I;
  end

  always_comb begin
    rdata = '0;
    case (ADR_I)
      3'd0: rdata[5:0] = {ovf, state == DONE, state == TRIG, state == ARMED, full, empty};
      3'd1: if (!empty) rdata = mem[rp];
      3'd2: rdata = mask;
      3'd3: rdata = value;
      3'd4: rdata[DIVBITS-1:0] = div;
      3'd5: rdata[PBITS-1:0] = post;
      3'd6: rdata[QBITS-1:0] = wp - rp;
      default: ;
    endcase
  end

  assign DAT_O = (ACK_O & ~WE_I) ? rdata : '0;
  assign IRQ_O = (state == DONE);
endmodule
